// File: rtl/bimodal_predictor_pkg.sv
// bp_pkg: shared counter width limit, saturating next-value function and testbench transaction record
package bp_pkg;
  localparam int CTR_MAX_W = 4;
  function automatic logic [CTR_MAX_W-1:0] sat_next(input logic [CTR_MAX_W-1:0] ctr, input logic taken, input int width);
    logic [CTR_MAX_W-1:0] top;
    top = CTR_MAX_W'((1 << width) - 1);
    return taken ? (ctr >= top ? top : ctr + 1'b1) : (ctr == '0 ? '0 : ctr - 1'b1);
  endfunction
  typedef struct packed {
    logic       req_valid;
    logic [7:0] req_pc;
    logic       upd_valid;
    logic [3:0] upd_idx;
    logic       upd_taken;
  } bp_txn_t;
endpackage

// File: rtl/bimodal_predictor_if.sv
// bimodal_predictor_if: request (req_valid/req_pc), prediction (pred_valid/pred_taken/pred_idx) and update (upd_valid/upd_idx/upd_taken) bundle
interface bimodal_predictor_if #(parameter int PC_W = 8, parameter int IDX_W = 4);
  logic             req_valid;
  logic [PC_W-1:0]  req_pc;
  logic             pred_valid;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  modport master (output req_valid, req_pc, upd_valid, upd_idx, upd_taken, input pred_valid, pred_taken, pred_idx);
  modport slave (input req_valid, req_pc, upd_valid, upd_idx, upd_taken, output pred_valid, pred_taken, pred_idx);
endinterface

// File: rtl/bimodal_predictor_sat_counter.sv
// sat_counter: up/down saturating counter (clk, rst_n sync active-low, inc_en update strobe, taken direction, value)
module sat_counter import bp_pkg::*; #(
  parameter int CTR_W = 2,
  parameter logic [CTR_W-1:0] CTR_INIT = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic             taken,
  output logic [CTR_W-1:0] value
);
  always_ff @(posedge clk)
    if (!rst_n) value <= CTR_INIT;
    else if (inc_en) value <= CTR_W'(sat_next(CTR_MAX_W'(value), taken, CTR_W));
endmodule

// File: rtl/bimodal_predictor.sv
// bimodal_predictor: PC-indexed saturating-counter direction predictor; ports clk, rst_n (sync active-low), bp (slave: req/pred/upd); option BIMODAL_GSHARE_EN xors a global history into the index
module bimodal_predictor import bp_pkg::*; #(
  parameter int PC_W = 8,
  parameter int PC_LSB = 2,
  parameter int IDX_W = 4,
  parameter int CTR_W = 2,
  parameter logic [CTR_W-1:0] CTR_INIT = '1
) (
  input logic clk,
  input logic rst_n,
  bimodal_predictor_if.slave bp
);
  if (PC_W < PC_LSB + IDX_W || CTR_W < 1 || CTR_W > CTR_MAX_W) begin : g_bad_cfg
    $error("bimodal_predictor: illegal PC_W/PC_LSB/IDX_W/CTR_W combination");
  end
  logic [IDX_W-1:0] pc_idx, idx;
  logic [CTR_W-1:0] ctr [2**IDX_W];
  assign pc_idx = bp.req_pc[PC_LSB+IDX_W-1:PC_LSB];
`ifdef BIMODAL_GSHARE_EN
  logic [IDX_W-1:0] ghr;
  always_ff @(posedge clk)
    if (!rst_n) ghr <= '0;
    else if (bp.upd_valid) ghr <= IDX_W'({ghr, bp.upd_taken});
  assign idx = pc_idx ^ ghr;
`else
  assign idx = pc_idx;
`endif
  for (genvar i = 0; i < 2**IDX_W; i++) begin : g_ctr
    sat_counter #(.CTR_W(CTR_W), .CTR_INIT(CTR_INIT)) u_ctr (
      .clk(clk),
      .rst_n(rst_n),
      .inc_en(bp.upd_valid && bp.upd_idx == IDX_W'(i)),
      .taken(bp.upd_taken),
      .value(ctr[i])
    );
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      bp.pred_valid <= 1'b0;
      bp.pred_taken <= 1'b0;
      bp.pred_idx <= '0;
    end else begin
      bp.pred_valid <= bp.req_valid;
      if (bp.req_valid) begin
        bp.pred_taken <= ctr[idx][CTR_W-1];
        bp.pred_idx <= idx;
      end
    end
endmodule
